// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational scalar ALU between NREQ requesters.
// Optional ALU_ARB_OPCHECK_EN rejects opcodes 001/111 with zeroed operands and an error response.
module alu_share_arbiter #(
    parameter int N    = 24,
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ*3-1:0] req_ctrl,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [N-1:0]      alu_result,
    input  logic [3:0]        alu_flags,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [N-1:0]      rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic [IDW-1:0]    gnt_id,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           state_q;
    logic [IDW-1:0]   rr_ptr_q, gnt_q, pick;
    logic [N-1:0]     a_q, b_q, res_q, raw_a, raw_b;
    logic [2:0]       ctrl_q, raw_ctrl;
    logic [3:0]       flags_q;
    logic             err_q, ill_q, found, bad, rsp_hs;
    logic [2*NREQ-1:0] rot;
    always_comb begin
        rot   = {req_valid, req_valid} >> rr_ptr_q;
        pick  = rr_ptr_q;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                pick  = IDW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end
    always_comb begin
        raw_a    = '0;
        raw_b    = '0;
        raw_ctrl = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == IDW'(i)) begin
                raw_a    = req_a[i*N +: N];
                raw_b    = req_b[i*N +: N];
                raw_ctrl = req_ctrl[i*3 +: 3];
            end
        end
    end
`ifdef ALU_ARB_OPCHECK_EN
    assign bad = (raw_ctrl == 3'b001) || (raw_ctrl == 3'b111);
`else
    assign bad = 1'b0;
`endif
    assign req_ready  = (state_q == IDLE && found) ? NREQ'(1) << pick : '0;
    assign rsp_valid  = (state_q == RESP) ? NREQ'(1) << gnt_q : '0;
    assign rsp_hs     = |(rsp_valid & rsp_ready);
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_result = res_q;
    assign rsp_flags  = flags_q;
    assign rsp_err    = err_q;
    assign gnt_id     = gnt_q;
    assign busy       = state_q != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            res_q    <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    // rejected opcodes still consume a slot but present a harmless add of zeros
                    a_q     <= bad ? '0 : raw_a;
                    b_q     <= bad ? '0 : raw_b;
                    ctrl_q  <= bad ? 3'b000 : raw_ctrl;
                    ill_q   <= bad;
                    gnt_q   <= pick;
                    state_q <= EXEC;
                end
                EXEC: begin
                    res_q   <= ill_q ? '0 : alu_result;
                    flags_q <= ill_q ? 4'b0000 : alu_flags;
                    err_q   <= ill_q;
                    state_q <= RESP;
                end
                RESP: if (rsp_hs) begin
                    err_q    <= 1'b0;
                    rr_ptr_q <= (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and random checks of the shared-ALU arbiter against a transaction-level model.
module tb_alu_share_arbiter;
    localparam int N = 24, NREQ = 2, IDW = 2;
    logic clk = 0, rst = 1;
    logic [NREQ-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
    logic [NREQ*N-1:0] req_a = '0, req_b = '0;
    logic [NREQ*3-1:0] req_ctrl = '0;
    logic [N-1:0] alu_a, alu_b, alu_result, rsp_result;
    logic [2:0] alu_ctrl;
    logic [3:0] alu_flags, rsp_flags;
    logic rsp_err, busy;
    logic [IDW-1:0] gnt_id;
    int n_chk = 0, n_fail = 0;
    int m_st = 0, m_ptr = 0, m_own = 0;
    logic [N-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic [2:0] m_c = '0;
    logic [3:0] m_fl = '0;
    logic m_ill = 0, m_err = 0;
`ifdef ALU_ARB_OPCHECK_EN
    localparam bit OPCHK = 1;
`else
    localparam bit OPCHK = 0;
`endif

    always #5 clk = ~clk;

    alu_share_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .gnt_id(gnt_id), .busy(busy));

    function automatic logic [N+3:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] c);
        logic [N:0] s;
        logic [N-1:0] r;
        logic cy, v;
        s = '0; r = '0; cy = 0; v = 0;
        if (c == 3'd1 || c == 3'd7) return '0;
        case (c)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[N-1:0]; cy = s[N]; v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]); end
            3'd2: begin s = {1'b0, a} + {1'b0, ~b} + 1; r = s[N-1:0]; cy = s[N]; v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]); end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            default: r = ($signed(a) < $signed(b)) ? N'(1) : '0;
        endcase
        return {r[N-1], r == '0, cy, v, r};
    endfunction

    assign {alu_flags, alu_result} = alu_f(alu_a, alu_b, alu_ctrl);

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // compare DUT against model at negedge, then advance model and clock by one cycle
    task automatic tick();
        int g;
        logic [N+3:0] r;
        @(negedge clk);
        g = (m_st == 0) ? pick(req_valid, m_ptr) : -1;
        chk("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("busy", busy, m_st != 0);
        chk("rsp_valid", rsp_valid, (m_st == 2) ? (64'd1 << m_own) : 64'd0);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_ctrl", alu_ctrl, m_c);
        chk("rsp_err", rsp_err, m_err);
        if (m_st != 0) chk("gnt_id", gnt_id, m_own);
        if (m_st == 2) begin
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_flags", rsp_flags, m_fl);
        end
        if (rst) begin
            m_st = 0; m_ptr = 0; m_own = 0; m_a = '0; m_b = '0; m_c = '0;
            m_res = '0; m_fl = '0; m_ill = 0; m_err = 0;
        end else if (m_st == 0 && g >= 0) begin
            m_own = g;
            m_a = req_a[g*N +: N];
            m_b = req_b[g*N +: N];
            m_c = req_ctrl[g*3 +: 3];
            m_ill = OPCHK && (m_c == 3'd1 || m_c == 3'd7);
            if (m_ill) begin m_a = '0; m_b = '0; m_c = '0; end
            m_st = 1;
        end else if (m_st == 1) begin
            r = m_ill ? '0 : alu_f(m_a, m_b, m_c);
            m_res = r[N-1:0];
            m_fl = r[N+3:N];
            m_err = m_ill;
            m_st = 2;
        end else if (m_st == 2 && rsp_ready[m_own]) begin
            m_ptr = (m_own + 1) % NREQ;
            m_err = 0;
            m_st = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk); #1;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_gnt_id", gnt_id, 0);
        rst = 0;

        req_valid = 2'b01; req_a[0 +: N] = 5; req_b[0 +: N] = 3; req_ctrl[0 +: 3] = 3'b000;
        #1 chk("add_ready", req_ready, 2'b01);
        tick(); req_valid = '0; tick();
        chk("add_valid", rsp_valid, 2'b01);
        chk("add_result", rsp_result, 8);
        chk("add_flags", rsp_flags, 4'b0000);
        chk("add_gnt", gnt_id, 0);
        rsp_ready = 2'b01; tick(); rsp_ready = '0;

        req_valid = 2'b10; req_a[N +: N] = 3; req_b[N +: N] = 5; req_ctrl[3 +: 3] = 3'b010;
        tick(); req_valid = '0; tick();
        chk("sub_valid", rsp_valid, 2'b10);
        chk("sub_result", rsp_result, 24'hFFFFFE);
        chk("sub_flags", rsp_flags, 4'b1000);
        rsp_ready = 2'b10; tick(); rsp_ready = '0;

        req_valid = 2'b11; req_a[0 +: N] = 10; req_b[0 +: N] = 20; req_ctrl[0 +: 3] = 3'b000;
        #1 chk("bp_ready0", req_ready, 2'b01);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            rsp_ready = 2'b10;
            tick();
            chk("bp_hold_result", rsp_result, 30);
            chk("bp_hold_ready", req_ready, 0);
        end
        rsp_ready = 2'b01; tick(); rsp_ready = '0;
        #1 chk("bp_next_ready1", req_ready, 2'b10);
        tick();
        chk("bp_next_gnt", gnt_id, 1);
        tick(); rsp_ready = 2'b10; tick();

        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int i = 0; i < 12; i++) tick();
        req_valid = '0;
        for (int i = 0; i < 3; i++) tick();

        req_valid = 2'b01; rsp_ready = '0; tick();
        req_valid = '0; rst = 1; tick(); rst = 0;
        chk("mid_busy", busy, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_alu_ctrl", alu_ctrl, 0);
        req_valid = 2'b11;
        #1 chk("mid_rrptr", req_ready, 2'b01);
        req_valid = 2'b10;
        #1 chk("mid_req1_ready", req_ready, 2'b10);
        tick();
        chk("mid_req1_gnt", gnt_id, 1);
        req_valid = '0; tick(); rsp_ready = 2'b11; tick();

        req_valid = 2'b01; rsp_ready = '0;
        req_a[0 +: N] = 7; req_b[0 +: N] = 9; req_ctrl[0 +: 3] = 3'b111;
        tick(); req_valid = '0; tick();
        chk("opc_err", rsp_err, OPCHK);
        chk("opc_result", rsp_result, 0);
        chk("opc_flags", rsp_flags, 0);
        chk("opc_alu_a", alu_a, OPCHK ? 0 : 7);
        rsp_ready = 2'b01; tick();
        chk("opc_err_clear", rsp_err, 0);

        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            req_valid = NREQ'($urandom);
            rsp_ready = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                req_a[i*N +: N] = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 4)) : N'($urandom);
                req_b[i*N +: N] = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 4)) : N'($urandom);
                req_ctrl[i*3 +: 3] = 3'($urandom_range(0, 7));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
